nt_cone_pipe: RTL and testbench
===============================

Name: nt_cone_pipe

Overview:
- Parametrised, multi-lane successor to the single-bit registered AND/OR–NAND/NOR cone subcircuit.
- Each lane computes or_term = (a & b) | c and side = ~d & e, registers or_term through a DEPTH-stage pipeline, and drives out = ~(or_q | side).
- Adds a valid pipeline, a stall enable, and a saturating hit counter with a sticky flag; used as a parametrised node subcircuit in the benchmark netlists.

Parameters:
- WIDTH, 4: number of independent bit-lanes.
- DEPTH, 1: register stages on the or_term path; legal range 1..8. DEPTH=1 gives the original single-DFF timing.
- CNT_W, 8: width of the hit counter.

Ports:
- core_clk  in  1  single clock, rising edge.
- core_rst  in  1  asynchronous, active-low reset.
- en  in  1  pipeline advance; 0 freezes all pipeline stages.
- in_valid  in  1  qualifies a, b, c, d, e.
- a  in  WIDTH  AND operand 0.
- b  in  WIDTH  AND operand 1.
- c  in  WIDTH  OR operand.
- d  in  WIDTH  side-path input, inverted.
- e  in  WIDTH  side-path input, NAND partner.
- clr  in  1  synchronous clear of the counter and sticky flag.
- out  out  WIDTH  ~(or_q | side), per lane.
- out_valid  out  1  in_valid delayed DEPTH stages.
- hit_cnt  out  CNT_W  count of valid cycles with out != 0, saturating.
- hit_sticky  out  1  set once any counted hit occurs.

Behaviour:
- Reset (core_rst=0, asynchronous assert, synchronous deassert handled upstream):
  - all or-pipe stages = 0, valid pipe = 0, hit_cnt = 0, hit_sticky = 0.
  - Reset mid-operation discards all in-flight data immediately; no partial flush.
- Pipeline:
  - Stage 0 captures (a&b)|c and in_valid when en=1.
  - Stage k captures stage k-1 when en=1.
  - When en=0, every stage holds its value; inputs are ignored.
  - Latency is DEPTH enabled edges from input to or_q and out_valid.
- Output, macro off:
  - out = ~(or_q | (~d & e)); the side term uses the current-cycle inputs (combinational, as in the original cone).
  - During reset, out = ~(~d & e) and out_valid = 0.
- Lanes are independent; there is no cross-lane logic.
- Counter and sticky flag, evaluated each rising edge:
  - clr=1: hit_cnt <= 0, hit_sticky <= 0. clr wins over a simultaneous hit; clr is independent of en.
  - else if out_valid=1 and en=1 and out != 0: hit_cnt increments, saturating at 2^CNT_W-1 (no wrap); hit_sticky <= 1.
  - Otherwise both hold.
- A frozen pipeline (en=0) never counts, even if out_valid=1.
- Bubbles (in_valid=0) propagate; their out values are still driven but are not counted.

Optional Feature:
- Macro: NT_CONE_SIDE_ALIGN_EN.
- Defined:
  - side = ~d & e is registered through its own DEPTH-stage pipeline, gated by en in the same way, so out = ~(or_q | side_q) aligned with out_valid.
  - Side stages reset to 0, so out resets to all-ones.
- Undefined: side path is combinational, as described above.

Decomposition:
- Package nt_cone_pkg holds:
  - the DEPTH_MAX = 8 constant;
  - a parameter-legality check function (1 <= DEPTH <= DEPTH_MAX, CNT_W >= 1);
  - a saturating-increment function.
- Sub-module nt_delay_line (WIDTH-bit, DEPTH-stage, enable, async active-low reset) is reused for the or path, the valid path and, when the macro is on, the side path.

Test Plan (WIDTH=4, DEPTH=2, CNT_W=4):
- Reset then inputs a=F, b=3, c=0, d=F, e=0, in_valid=1, en=1 -> out_valid rises on edge 2; or_q=3; out=C; hit_cnt=1 on edge 3.
- Macro off, a=b=c=0 in the pipe, then d=0, e=5 -> out=A in the same cycle; the out change is combinational with no edge.
- en held 0 for 3 cycles mid-stream -> or_q, out_valid and hit_cnt all frozen; resuming en=1 continues with no lost or duplicated sample.
- 20 consecutive valid hits -> hit_cnt saturates at F; clr asserted together with a hit -> hit_cnt=0, hit_sticky=0.
- core_rst pulsed low between edges while out_valid=1 -> out_valid, hit_cnt and hit_sticky drop to 0 immediately; the first new sample appears 2 enabled edges after release.
- Macro on: d=0, e=F presented with in_valid=1 -> out=0 exactly when out_valid=1 (edge 2), not earlier.

Source files
------------

// File: rtl/nt_cone_pkg.sv
// Shared constants and helpers for the nt_cone_pipe node subcircuit.
// Holds the depth limit, the parameter-legality check and the saturating counter step.
package nt_cone_pkg;

  localparam int DEPTH_MAX = 8;
  localparam int CNT_W_MAX = 32;

  function automatic bit params_ok(input int depth, input int cnt_w);
    return (depth >= 1) && (depth <= DEPTH_MAX) && (cnt_w >= 1) && (cnt_w <= CNT_W_MAX);
  endfunction

  // Counter values are carried zero-extended to 32 bits; width sets the saturation point.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/nt_delay_line.sv
// WIDTH-bit, DEPTH-stage register delay line; latency DEPTH enabled edges.
// en=0 freezes every stage (no bubble squeeze); async active-low reset clears all stages.
module nt_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1
) (
  input  logic             core_clk,
  input  logic             core_rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stg [DEPTH];

  always_ff @(posedge core_clk or negedge core_rst) begin
    if (!core_rst) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
    end else if (en) begin
      stg[0] <= din;
      for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
    end
  end

  assign dout = stg[DEPTH-1];

endmodule

// File: rtl/nt_cone_pipe.sv
// Multi-lane registered AND/OR-NAND/NOR cone with valid pipe and saturating hit counter; DEPTH-edge latency.
// en=0 stalls all stages and counting; NT_CONE_SIDE_ALIGN_EN registers the side term to align it with out_valid.
module nt_cone_pipe
  import nt_cone_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             core_clk,
  input  logic             core_rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             hit_sticky
);

  if (!params_ok(DEPTH, CNT_W)) begin : g_bad_params
    $error("nt_cone_pipe: DEPTH must be 1..%0d and CNT_W 1..%0d", DEPTH_MAX, CNT_W_MAX);
  end

  logic [WIDTH-1:0] or_term;
  logic [WIDTH-1:0] side;
  logic [WIDTH-1:0] or_q;
  logic [WIDTH-1:0] side_use;
  logic [31:0]      cnt_inc;
  logic             unused_cnt_bits;

  assign or_term = (a & b) | c;
  assign side    = ~d & e;

  nt_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_or_pipe (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .en       (en),
    .din      (or_term),
    .dout     (or_q)
  );

  nt_delay_line #(.WIDTH(1), .DEPTH(DEPTH)) u_vld_pipe (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .en       (en),
    .din      (in_valid),
    .dout     (out_valid)
  );

`ifdef NT_CONE_SIDE_ALIGN_EN
  nt_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_side_pipe (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .en       (en),
    .din      (side),
    .dout     (side_use)
  );
`else
  // Side term stays combinational from the current inputs, matching the original cone timing.
  assign side_use = side;
`endif

  assign out = ~(or_q | side_use);

  assign cnt_inc         = sat_inc(32'(hit_cnt), CNT_W);
  assign unused_cnt_bits = ^{cnt_inc, 1'b0};

  always_ff @(posedge core_clk or negedge core_rst) begin
    if (!core_rst) begin
      hit_cnt    <= '0;
      hit_sticky <= 1'b0;
    end else if (clr) begin
      hit_cnt    <= '0;
      hit_sticky <= 1'b0;
    end else if (out_valid && en && (out != '0)) begin
      hit_cnt    <= cnt_inc[CNT_W-1:0];
      hit_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nt_cone_pipe.sv
// Directed bench for nt_cone_pipe at WIDTH=4, DEPTH=2, CNT_W=4; expectations follow NT_CONE_SIDE_ALIGN_EN when defined.
module tb_nt_cone_pipe;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
`ifdef NT_CONE_SIDE_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic             core_clk;
  logic             core_rst;
  logic             en;
  logic             in_valid;
  logic [WIDTH-1:0] a, b, c, d, e;
  logic             clr;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic [CNT_W-1:0] hit_cnt;
  logic             hit_sticky;

  int checks = 0;
  int errors = 0;

  nt_cone_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .core_clk   (core_clk),
    .core_rst   (core_rst),
    .en         (en),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .e          (e),
    .clr        (clr),
    .out        (out),
    .out_valid  (out_valid),
    .hit_cnt    (hit_cnt),
    .hit_sticky (hit_sticky)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    core_rst = 1'b1; en = 1'b0; in_valid = 1'b0; clr = 1'b0;
    a = 4'h0; b = 4'h0; c = 4'h0; d = 4'h0; e = 4'h5;
    #1 core_rst = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'h0);
    check("rst_hit_sticky", 32'(hit_sticky), 32'h0);
    check("rst_out", 32'(out), ALIGN ? 32'hF : 32'hA);
    tick();
    check("rst_hold_out_valid", 32'(out_valid), 32'h0);

    // Release between edges and start the first sample: or_term = 3, side = 0.
    #2 core_rst = 1'b1;
    a = 4'hF; b = 4'h3; c = 4'h0; d = 4'hF; e = 4'h0; in_valid = 1'b1; en = 1'b1;
    tick();
    check("e1_out_valid", 32'(out_valid), 32'h0);
    check("e1_hit_cnt", 32'(hit_cnt), 32'h0);
    tick();
    check("e2_out_valid", 32'(out_valid), 32'h1);
    check("e2_out", 32'(out), 32'hC);
    check("e2_hit_cnt", 32'(hit_cnt), 32'h0);
    a = 4'h0; b = 4'h0; c = 4'h0;
    tick();
    check("e3_hit_cnt", 32'(hit_cnt), 32'h1);
    check("e3_hit_sticky", 32'(hit_sticky), 32'h1);
    check("e3_out", 32'(out), 32'hC);
    tick();
    check("e4_out_zero_pipe", 32'(out), 32'hF);
    check("e4_hit_cnt", 32'(hit_cnt), 32'h2);

    // Side path change with no clock edge in between.
    en = 1'b0;
    d = 4'h0; e = 4'h5;
    #1;
    check("comb_side_out", 32'(out), ALIGN ? 32'hF : 32'hA);
    d = 4'hF; e = 4'h0;

    // Sample S1 (or=1) enters, then stall 3 edges with garbage inputs.
    en = 1'b1; a = 4'h1; b = 4'h1; c = 4'h0; in_valid = 1'b1;
    tick();
    check("e5_hit_cnt", 32'(hit_cnt), 32'h3);
    en = 1'b0; a = 4'hF; b = 4'hF; c = 4'h8; in_valid = 1'b0;
    tick(); tick(); tick();
    check("frz_out", 32'(out), 32'hF);
    check("frz_out_valid", 32'(out_valid), 32'h1);
    check("frz_hit_cnt", 32'(hit_cnt), 32'h3);

    // Resume with sample S2 (or=2): S1 must emerge first, then S2.
    en = 1'b1; a = 4'h0; b = 4'h0; c = 4'h2; in_valid = 1'b1;
    tick();
    check("res_s1_out", 32'(out), 32'hE);
    check("res_s1_hit_cnt", 32'(hit_cnt), 32'h4);
    c = 4'h0; in_valid = 1'b0;
    tick();
    check("res_s2_out", 32'(out), 32'hD);
    check("res_s2_out_valid", 32'(out_valid), 32'h1);
    check("res_s2_hit_cnt", 32'(hit_cnt), 32'h5);
    tick();
    check("bub_out", 32'(out), 32'hF);
    check("bub_out_valid", 32'(out_valid), 32'h0);
    check("bub_hit_cnt_a", 32'(hit_cnt), 32'h6);
    tick();
    check("bub_hit_cnt_b", 32'(hit_cnt), 32'h6);

    // Clear, then a long run of hits to saturate.
    clr = 1'b1; in_valid = 1'b1;
    tick();
    check("clr_hit_cnt", 32'(hit_cnt), 32'h0);
    check("clr_hit_sticky", 32'(hit_sticky), 32'h0);
    clr = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_hit_cnt", 32'(hit_cnt), 32'hF);
    check("sat_hit_sticky", 32'(hit_sticky), 32'h1);
    clr = 1'b1;
    tick();
    check("clr_vs_hit_cnt", 32'(hit_cnt), 32'h0);
    check("clr_vs_hit_sticky", 32'(hit_sticky), 32'h0);
    clr = 1'b0;
    tick();
    check("pre_rst_out_valid", 32'(out_valid), 32'h1);

    // Asynchronous reset pulse between edges.
    #2 core_rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_hit_cnt", 32'(hit_cnt), 32'h0);
    check("arst_hit_sticky", 32'(hit_sticky), 32'h0);
    check("arst_out", 32'(out), 32'hF);
    #1 core_rst = 1'b1;
    c = 4'h4;
    tick();
    check("rr1_out_valid", 32'(out_valid), 32'h0);
    tick();
    check("rr2_out_valid", 32'(out_valid), 32'h1);
    check("rr2_out", 32'(out), 32'hB);

    // Side term d=0, e=F: combinational build drops out at once, aligned build two edges later.
    c = 4'h0; d = 4'h0; e = 4'hF;
    #1;
    check("side_e0_out", 32'(out), ALIGN ? 32'hB : 32'h0);
    tick();
    check("side_e1_out", 32'(out), ALIGN ? 32'hB : 32'h0);
    tick();
    check("side_e2_out", 32'(out), 32'h0);
    check("side_e2_out_valid", 32'(out_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
